// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU control codes, MIPS opcode/funct values, operand
// select encodings and the ID/EX control bundle carried into EX.
package cpu_pkg;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5;
    localparam logic [4:0] ALU_SLT = 5'd6;
    localparam logic [4:0] ALU_SLL = 5'd7;
    localparam logic [4:0] ALU_SRL = 5'd8;
    localparam logic [4:0] ALU_SRA = 5'd9;

    localparam logic [1:0] A_RS   = 2'd0;
    localparam logic [1:0] A_RT   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [1:0] B_RT  = 2'd0;
    localparam logic [1:0] B_IMM = 2'd1;
    localparam logic [1:0] B_RS  = 2'd2;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef struct packed {
        logic        valid;
        logic [4:0]  alu_ctrl;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  branch;
        logic        illegal;
    } id_ex_t;

    function automatic logic [4:0] funct_alu(input logic [5:0] funct);
        logic [4:0] r_code;
        case (funct)
            F_SUB, F_SUBU:  r_code = ALU_SUB;
            F_AND:          r_code = ALU_AND;
            F_OR:           r_code = ALU_OR;
            F_XOR:          r_code = ALU_XOR;
            F_NOR:          r_code = ALU_NOR;
            F_SLT:          r_code = ALU_SLT;
            F_SLL, F_SLLV:  r_code = ALU_SLL;
            F_SRL, F_SRLV:  r_code = ALU_SRL;
            F_SRA, F_SRAV:  r_code = ALU_SRA;
            default:        r_code = ALU_ADD;
        endcase
        return r_code;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary signals: decode inputs and stall/flush controls in, registered
// EX control bundle and the combinational load-use stall out.
interface id_ex_stage_if;
    import cpu_pkg::*;

    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_stall;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [4:0]  ex_alu_ctrl;
    logic [1:0]  ex_a_sel;
    logic [1:0]  ex_b_sel;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_branch;
    logic        ex_illegal;

    modport master (
        output id_valid, id_instr, ex_stall, flush,
        input  id_stall, ex_valid, ex_alu_ctrl, ex_a_sel, ex_b_sel, ex_imm,
               ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_branch, ex_illegal
    );

    modport slave (
        input  id_valid, id_instr, ex_stall, flush,
        output id_stall, ex_valid, ex_alu_ctrl, ex_a_sel, ex_b_sel, ex_imm,
               ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_branch, ex_illegal
    );
endinterface

// File: rtl/id_decode.sv
// Combinational MIPS decoder: instruction word to EX control bundle, plus
// which source registers the instruction actually reads (for hazard checks).
module id_decode
    import cpu_pkg::*;
(
    input  logic [31:0] i_instr,
    output id_ex_t      o_ctrl,
    output logic        o_uses_rs,
    output logic        o_uses_rt
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;

    assign w_opcode   = i_instr[31:26];
    assign w_rs       = i_instr[25:21];
    assign w_rt       = i_instr[20:16];
    assign w_rd       = i_instr[15:11];
    assign w_shamt    = i_instr[10:6];
    assign w_funct    = i_instr[5:0];
    assign w_imm_sext = {{16{i_instr[15]}}, i_instr[15:0]};
    assign w_imm_zext = {16'h0000, i_instr[15:0]};

    always_comb begin
        o_ctrl       = '0;
        o_ctrl.valid = 1'b1;
        o_ctrl.rs    = w_rs;
        o_ctrl.rt    = w_rt;
        o_uses_rs    = 1'b0;
        o_uses_rt    = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT: begin
                        o_ctrl.alu_ctrl  = funct_alu(w_funct);
                        o_ctrl.a_sel     = A_RS;
                        o_ctrl.b_sel     = B_RT;
                        o_ctrl.dest      = w_rd;
                        o_ctrl.reg_write = 1'b1;
                        o_uses_rs        = 1'b1;
                        o_uses_rt        = 1'b1;
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        o_ctrl.alu_ctrl  = funct_alu(w_funct);
                        o_ctrl.a_sel     = A_RT;
                        o_ctrl.b_sel     = B_IMM;
                        o_ctrl.imm       = {27'd0, w_shamt};
                        o_ctrl.dest      = w_rd;
                        o_ctrl.reg_write = 1'b1;
                        o_uses_rt        = 1'b1;
                    end
                    F_SLLV, F_SRLV, F_SRAV: begin
                        o_ctrl.alu_ctrl  = funct_alu(w_funct);
                        o_ctrl.a_sel     = A_RT;
                        o_ctrl.b_sel     = B_RS;
                        o_ctrl.dest      = w_rd;
                        o_ctrl.reg_write = 1'b1;
                        o_uses_rs        = 1'b1;
                        o_uses_rt        = 1'b1;
                    end
                    // jr target is read in ID by the front end, so rs still matters
                    F_JR:    o_uses_rs      = 1'b1;
                    default: o_ctrl.illegal = 1'b1;
                endcase
            end
            OP_J: ;
            OP_BEQ, OP_BNE: begin
                o_ctrl.alu_ctrl = ALU_SUB;
                o_ctrl.a_sel    = A_RS;
                o_ctrl.b_sel    = B_RT;
                o_ctrl.imm      = w_imm_sext;
                o_ctrl.branch   = (w_opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
                o_uses_rs       = 1'b1;
                o_uses_rt       = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                o_ctrl.alu_ctrl  = (w_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                o_ctrl.b_sel     = B_IMM;
                o_ctrl.imm       = w_imm_sext;
                o_ctrl.dest      = w_rt;
                o_ctrl.reg_write = 1'b1;
                o_uses_rs        = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                o_ctrl.alu_ctrl  = (w_opcode == OP_ANDI) ? ALU_AND :
                                   (w_opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                o_ctrl.b_sel     = B_IMM;
                o_ctrl.imm       = w_imm_zext;
                o_ctrl.dest      = w_rt;
                o_ctrl.reg_write = 1'b1;
                o_uses_rs        = 1'b1;
            end
            OP_LUI: begin
                o_ctrl.a_sel     = A_ZERO;
                o_ctrl.b_sel     = B_IMM;
                o_ctrl.imm       = {i_instr[15:0], 16'h0000};
                o_ctrl.dest      = w_rt;
                o_ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                o_ctrl.b_sel     = B_IMM;
                o_ctrl.imm       = w_imm_sext;
                o_ctrl.dest      = w_rt;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mem_read  = 1'b1;
                o_uses_rs        = 1'b1;
            end
            OP_SW: begin
                o_ctrl.b_sel     = B_IMM;
                o_ctrl.imm       = w_imm_sext;
                o_ctrl.mem_write = 1'b1;
                o_uses_rs        = 1'b1;
                o_uses_rt        = 1'b1;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
        // $0 is hardwired; a write to it must never reach the register file
        if (o_ctrl.dest == 5'd0) begin
            o_ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ID instruction, detects load-use
// hazards and inserts bubbles on flush, stall or idle ID.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    id_ex_t w_dec;
    id_ex_t r_ex;
    logic   w_uses_rs;
    logic   w_uses_rt;
    logic   w_rs_hit;
    logic   w_rt_hit;
    logic   w_hazard;
    logic   w_bubble;

    id_decode u_decode (
        .i_instr   (bus.id_instr),
        .o_ctrl    (w_dec),
        .o_uses_rs (w_uses_rs),
        .o_uses_rt (w_uses_rt)
    );

    assign w_rs_hit = w_uses_rs & (w_dec.rs == r_ex.dest);
    assign w_rt_hit = w_uses_rt & (w_dec.rt == r_ex.dest);
    // a flush kills the consumer anyway, so it must not also hold upstream
    assign w_hazard = bus.id_valid & r_ex.valid & r_ex.mem_read & (r_ex.dest != 5'd0) &
                      ~bus.flush & (w_rs_hit | w_rt_hit);
    assign w_bubble = bus.flush | w_hazard | ~bus.id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex <= '0;
        end else if (bus.ex_stall) begin
            r_ex <= r_ex;
        end else if (w_bubble) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_dec;
        end
    end

    assign bus.id_stall     = w_hazard;
    assign bus.ex_valid     = r_ex.valid;
    assign bus.ex_alu_ctrl  = r_ex.alu_ctrl;
    assign bus.ex_a_sel     = r_ex.a_sel;
    assign bus.ex_b_sel     = r_ex.b_sel;
    assign bus.ex_imm       = r_ex.imm;
    assign bus.ex_rs        = r_ex.rs;
    assign bus.ex_rt        = r_ex.rt;
    assign bus.ex_dest      = r_ex.dest;
    assign bus.ex_reg_write = r_ex.reg_write;
    assign bus.ex_mem_read  = r_ex.mem_read;
    assign bus.ex_mem_write = r_ex.mem_write;
    assign bus.ex_branch    = r_ex.branch;
    assign bus.ex_illegal   = r_ex.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode vectors, load-use stall, ex_stall
// hold, flush bubbles and mid-stream reset, with hand-computed expectations.
module tb_id_ex_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] instr);
        bus.id_valid = valid;
        bus.id_instr = instr;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.id_valid = 1'b0;
        bus.id_instr = 32'h0;
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_alu", {27'd0, bus.ex_alu_ctrl}, 32'd0);
        chk("rst_imm", bus.ex_imm, 32'd0);
        chk("rst_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("rst_stall", {31'd0, bus.id_stall}, 32'd0);
        rst = 1'b0;

        // add $3,$1,$2
        drive(1'b1, 32'h00221820);
        tick();
        $display("[TB] add $3,$1,$2");
        chk("add_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("add_alu", {27'd0, bus.ex_alu_ctrl}, 32'd0);
        chk("add_asel", {30'd0, bus.ex_a_sel}, 32'd0);
        chk("add_bsel", {30'd0, bus.ex_b_sel}, 32'd0);
        chk("add_dest", {27'd0, bus.ex_dest}, 32'd3);
        chk("add_rw", {31'd0, bus.ex_reg_write}, 32'd1);
        chk("add_rs", {27'd0, bus.ex_rs}, 32'd1);
        chk("add_rt", {27'd0, bus.ex_rt}, 32'd2);

        // sll $4,$5,3
        drive(1'b1, 32'h000520C0);
        tick();
        $display("[TB] sll $4,$5,3");
        chk("sll_alu", {27'd0, bus.ex_alu_ctrl}, 32'd7);
        chk("sll_asel", {30'd0, bus.ex_a_sel}, 32'd1);
        chk("sll_bsel", {30'd0, bus.ex_b_sel}, 32'd1);
        chk("sll_imm", bus.ex_imm, 32'h00000003);
        chk("sll_dest", {27'd0, bus.ex_dest}, 32'd4);

        // addi $2,$0,-1
        drive(1'b1, 32'h2002FFFF);
        tick();
        $display("[TB] addi $2,$0,-1");
        chk("addi_imm", bus.ex_imm, 32'hFFFFFFFF);
        chk("addi_alu", {27'd0, bus.ex_alu_ctrl}, 32'd0);
        chk("addi_bsel", {30'd0, bus.ex_b_sel}, 32'd1);
        chk("addi_dest", {27'd0, bus.ex_dest}, 32'd2);

        // andi $2,$0,0xFFFF
        drive(1'b1, 32'h3002FFFF);
        tick();
        $display("[TB] andi $2,$0,0xFFFF");
        chk("andi_imm", bus.ex_imm, 32'h0000FFFF);
        chk("andi_alu", {27'd0, bus.ex_alu_ctrl}, 32'd2);

        // lui $1,0x1234
        drive(1'b1, 32'h3C011234);
        tick();
        $display("[TB] lui $1,0x1234");
        chk("lui_imm", bus.ex_imm, 32'h12340000);
        chk("lui_asel", {30'd0, bus.ex_a_sel}, 32'd2);
        chk("lui_dest", {27'd0, bus.ex_dest}, 32'd1);

        // srav $6,$7,$8 : a=rt, b=rs
        drive(1'b1, 32'h01073007);
        tick();
        $display("[TB] srav $6,$7,$8");
        chk("srav_alu", {27'd0, bus.ex_alu_ctrl}, 32'd9);
        chk("srav_bsel", {30'd0, bus.ex_b_sel}, 32'd2);

        // add $0,$1,$2 : write to $0 suppressed
        drive(1'b1, 32'h00220020);
        tick();
        $display("[TB] add $0,$1,$2");
        chk("zero_rw", {31'd0, bus.ex_reg_write}, 32'd0);

        // lw $5,0($1) then add $3,$5,$2 : load-use stall
        drive(1'b1, 32'h8C250000);
        tick();
        $display("[TB] lw $5,0($1)");
        chk("lw_mr", {31'd0, bus.ex_mem_read}, 32'd1);
        chk("lw_rw", {31'd0, bus.ex_reg_write}, 32'd1);
        chk("lw_dest", {27'd0, bus.ex_dest}, 32'd5);
        drive(1'b1, 32'h00A21820);
        #1;
        $display("[TB] add $3,$5,$2 behind lw");
        chk("lu_stall", {31'd0, bus.id_stall}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
        chk("lu_bub_mr", {31'd0, bus.ex_mem_read}, 32'd0);
        chk("lu_unstall", {31'd0, bus.id_stall}, 32'd0);
        tick();
        chk("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("lu_add_rs", {27'd0, bus.ex_rs}, 32'd5);
        chk("lu_add_dest", {27'd0, bus.ex_dest}, 32'd3);

        // lw in EX: addi with rt==dest does not stall; flush suppresses stall
        drive(1'b1, 32'h8C250000);
        tick();
        drive(1'b1, 32'h20250001);
        #1;
        $display("[TB] addi $5,$1,1 behind lw");
        chk("imm_rt_nostall", {31'd0, bus.id_stall}, 32'd0);
        drive(1'b1, 32'h00A21820);
        bus.flush = 1'b1;
        #1;
        $display("[TB] flush with hazard");
        chk("flush_nostall", {31'd0, bus.id_stall}, 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("flush_bubble", {31'd0, bus.ex_valid}, 32'd0);

        // ex_stall holds outputs for 3 cycles; flush under stall is ignored
        drive(1'b1, 32'h00221820);
        tick();
        bus.ex_stall = 1'b1;
        drive(1'b1, 32'h000520C0);
        $display("[TB] ex_stall hold");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_dest", {27'd0, bus.ex_dest}, 32'd3);
            chk("hold_alu", {27'd0, bus.ex_alu_ctrl}, 32'd0);
        end
        bus.flush = 1'b1;
        tick();
        chk("hold_flush_valid", {31'd0, bus.ex_valid}, 32'd1);
        bus.flush    = 1'b0;
        bus.ex_stall = 1'b0;

        // beq $1,$2,4 then bne flushed
        drive(1'b1, 32'h10220004);
        tick();
        $display("[TB] beq $1,$2,4");
        chk("beq_br", {30'd0, bus.ex_branch}, 32'd1);
        chk("beq_alu", {27'd0, bus.ex_alu_ctrl}, 32'd1);
        chk("beq_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("beq_imm", bus.ex_imm, 32'd4);
        drive(1'b1, 32'h14220004);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        $display("[TB] bne flushed");
        chk("bne_flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("bne_flush_br", {30'd0, bus.ex_branch}, 32'd0);

        // sw $5,8($1)
        drive(1'b1, 32'hAC250008);
        tick();
        $display("[TB] sw $5,8($1)");
        chk("sw_mw", {31'd0, bus.ex_mem_write}, 32'd1);
        chk("sw_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("sw_imm", bus.ex_imm, 32'd8);

        // illegal opcode 0x3F, jal illegal, j legal no-op
        drive(1'b1, 32'hFC000000);
        tick();
        $display("[TB] opcode 0x3F");
        chk("ill_flag", {31'd0, bus.ex_illegal}, 32'd1);
        chk("ill_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("ill_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("ill_mr", {31'd0, bus.ex_mem_read}, 32'd0);
        chk("ill_mw", {31'd0, bus.ex_mem_write}, 32'd0);
        drive(1'b1, 32'h0C000010);
        tick();
        $display("[TB] jal");
        chk("jal_ill", {31'd0, bus.ex_illegal}, 32'd1);
        drive(1'b1, 32'h08000010);
        tick();
        $display("[TB] j");
        chk("j_ill", {31'd0, bus.ex_illegal}, 32'd0);
        chk("j_valid", {31'd0, bus.ex_valid}, 32'd1);

        // id_valid low gives a bubble
        drive(1'b0, 32'h00221820);
        tick();
        $display("[TB] id_valid low");
        chk("idle_valid", {31'd0, bus.ex_valid}, 32'd0);

        // reset mid-hazard and mid-stall
        drive(1'b1, 32'h8C250000);
        tick();
        drive(1'b1, 32'h00A21820);
        bus.ex_stall = 1'b1;
        rst = 1'b1;
        tick();
        $display("[TB] rst mid-stream");
        chk("mrst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("mrst_mr", {31'd0, bus.ex_mem_read}, 32'd0);
        chk("mrst_dest", {27'd0, bus.ex_dest}, 32'd0);
        chk("mrst_imm", bus.ex_imm, 32'd0);
        chk("mrst_stall", {31'd0, bus.id_stall}, 32'd0);
        rst          = 1'b0;
        bus.ex_stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Instruction decode and ID/EX pipeline register for the 5-stage MIPS pipeline. Turns a 32-bit instruction from IF/ID into the registered control bundle consumed by EX: the 5-bit ALU control code, operand selects, the formed immediate, and memory/writeback/branch controls. It also detects load-use hazards and handles stall, flush and bubble insertion between ID and EX.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  id_instr holds a real instruction
- id_instr  in  32  instruction from IF/ID
- ex_stall  in  1  EX cannot advance; hold all registers
- flush  in  1  branch taken; kill the instruction in ID
- id_stall  out  1  combinational load-use stall; upstream holds PC and IF/ID
- ex_valid  out  1  EX slot holds a real instruction
- ex_alu_ctrl  out  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 SRA
- ex_a_sel  out  2  ALU A source: 0 rs data, 1 rt data, 2 zero
- ex_b_sel  out  2  ALU B source: 0 rt data, 1 ex_imm, 2 rs data
- ex_imm  out  32  formed immediate
- ex_rs, ex_rt  out  5 each  source register numbers, for forwarding
- ex_dest  out  5  writeback register number
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- ex_branch  out  2  0 none, 1 beq, 2 bne
- ex_illegal  out  1  unsupported opcode or funct

## Operation
- R-type arithmetic and logic (add/addu/sub/subu/and/or/xor/nor/slt):
  - a_sel=0, b_sel=0, dest=rd, reg_write=1.
- Shifts by shamt (sll/srl/sra):
  - ctrl 7/8/9, a_sel=1, b_sel=1, imm=zero-extended shamt.
- Variable shifts (sllv/srlv/srav): a_sel=1, b_sel=2.
- Sign-extended immediate ops:
  - addi/addiu: ctrl 0.
  - slti: ctrl 6.
  - All: b_sel=1, dest=rt.
- Zero-extended immediate ops (andi/ori/xori): ctrl 2/3/4.
- lui: a_sel=2, b_sel=1, imm={imm16,16'h0}, ctrl 0.
- lw/sw:
  - ctrl 0, sign-extended imm.
  - lw: mem_read=1, reg_write=1, dest=rt.
  - sw: mem_write=1.
- beq/bne: ctrl 1 (SUB, so the ALU zero flag is valid), b_sel=0, ex_branch=1/2, no writes.
- j and jr: resolved by the front end; here they are valid no-ops with all writes 0.
- jal and any other opcode/funct:
  - ex_illegal=1, ex_valid=1.
  - reg_write, mem_read, mem_write all 0; branch=0.
- Writes to dest 0: reg_write is forced to 0.
- Load-use hazard:
  - id_stall = id_valid & ex_valid & ex_mem_read & (ex_dest!=0) & ~flush & ((uses_rs & rs==ex_dest) | (uses_rt & rt==ex_dest)).
  - uses_rt is 0 for immediate ops, lw and lui.
  - sw and beq/bne use rt.
- Bubble = ex_valid=0 and all control outputs 0; data fields don't-care, driven 0.

## Timing
- Every output is registered except id_stall. Latency from id_instr to ex_* is 1 cycle.
- Register update priority each cycle: rst > ex_stall (hold) > flush (bubble) > id_stall (bubble) > ~id_valid (bubble) > capture decode.
- Reset value of every registered output is 0, including ex_alu_ctrl=0 (ADD) and ex_valid=0.
- Reset asserted mid-stall or mid-hazard: next cycle all outputs are 0, regardless of other inputs.
- id_stall is evaluated even while ex_stall is high; upstream must hold when either is high.
- flush with ex_stall: hold wins, and the flush is ignored that cycle. The front end never asserts both.
- flush together with a hazard: id_stall=0 and a bubble is inserted.
- A load-use stall lasts exactly 1 cycle. After the bubble, ex_mem_read=0, so the held instruction is captured on the next edge.

## Structure
- Shared package cpu_pkg holds:
  - ALU control constants 0–9 (shared with the ALU).
  - Opcode and funct constants.
  - a_sel/b_sel/branch encodings.
- Combinational sub-module id_decode: maps instr to the control bundle plus uses_rs/uses_rt. The parent holds the hazard logic and registers.

## Test plan
- add $3,$1,$2 (0x00221820), id_valid=1 -> next cycle: ex_valid=1, ctrl=0, a_sel=0, b_sel=0, dest=3, reg_write=1.
- sll $4,$5,3 (0x000520C0) -> ctrl=7, a_sel=1, b_sel=1, imm=0x00000003, dest=4.
- addi $2,$0,-1 (0x2002FFFF) -> imm=0xFFFFFFFF. andi $2,$0,0xFFFF (0x3002FFFF) -> imm=0x0000FFFF, ctrl=2.
- Load-use:
  - Stimulus: lw $5,0($1) (0x8C250000), then add $3,$5,$2 (0x00A21820).
  - id_stall=1 for one cycle, then a bubble (ex_valid=0).
  - The add appears in EX next, with rs=5.
- Stall, flush and reset:
  - ex_stall held 3 cycles -> outputs unchanged.
  - flush during a valid beq in ID -> ex_valid=0.
  - rst mid-stream -> all outputs 0 next cycle.
- Illegal opcode 0x3F -> ex_illegal=1, ex_valid=1, reg_write=0, mem_read=0, mem_write=0.
